// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle control path: state encodings,
// opcodes, datapath mux encodings and the bundled control word.
package multicycle_pkg;

  localparam int OPCODE_W = 4;
  localparam int STATE_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_LW    = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_SW    = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_J     = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 4'hF;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_OFF  = 2'b11;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch_cond;
    logic       branch_ne_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       halted;
  } ctrl_t;

  // True for every opcode the machine implements
  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_J, OP_HALT: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the sequencing FSM (master) and the datapath (slave).
interface multicycle_control_if;
  import multicycle_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                PCWrite;
  logic                branchCond;
  logic                branchNECond;
  logic                IRWrite;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                RegWrite;
  logic                MemtoReg;
  logic                RegDst;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic [1:0]          PCSource;
  logic                illegal_op;
  logic                halted;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, branchCond, branchNECond, IRWrite, IorD, MemRead, MemWrite,
           RegWrite, MemtoReg, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, halted
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, branchCond, branchNECond, IRWrite, IorD, MemRead, MemWrite,
           RegWrite, MemtoReg, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, halted
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational control-word decode from the current state. PC/IR loads in
// FETCH are qualified by mem_ready; reset forces the whole word low so a
// pending memory request drops without waiting for a clock edge.
module control_decode
  import multicycle_pkg::*;
(
  input  state_e              state_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [OPCODE_W-1:0] op_q_i,
  input  logic                mem_ready_i,
  input  logic                reset_i,
  output ctrl_t               ctrl_o
);

  ctrl_t ctrl_s;

  // Map each state to its datapath controls
  always_comb begin
    ctrl_s = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.alu_src_b = SRCB_ONE;
        ctrl_s.alu_op    = ALUOP_ADD;
        ctrl_s.pc_source = PCSRC_ALU;
        ctrl_s.ir_write  = mem_ready_i;
        ctrl_s.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_s.alu_src_b  = SRCB_OFF;
        ctrl_s.alu_op     = ALUOP_ADD;
        ctrl_s.illegal_op = ~is_legal_op(opcode_i);
      end
      S_MEM_ADDR, S_EXEC_I: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl_s.mem_read = 1'b1;
        ctrl_s.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_s.mem_write = 1'b1;
        ctrl_s.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_REGB;
        ctrl_s.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.reg_dst   = (op_q_i == OP_RTYPE);
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a      = 1'b1;
        ctrl_s.alu_src_b      = SRCB_REGB;
        ctrl_s.alu_op         = ALUOP_SUB;
        ctrl_s.pc_source      = PCSRC_ALUOUT;
        ctrl_s.branch_cond    = (op_q_i == OP_BEQ);
        ctrl_s.branch_ne_cond = (op_q_i == OP_BNE);
      end
      S_JUMP: begin
        ctrl_s.pc_write  = 1'b1;
        ctrl_s.pc_source = PCSRC_JUMP;
      end
      S_HALT: begin
        ctrl_s.halted = 1'b1;
      end
      default: begin
        ctrl_s = '0;
      end
    endcase
  end

  assign ctrl_o = reset_i ? ctrl_t'('0) : ctrl_s;

endmodule

// File: rtl/multicycle_control.sv
// Sequencing FSM for the 16-bit multicycle datapath. Holds the state register,
// the opcode latched in DECODE, and the next-state logic; the control word is
// produced by control_decode.
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  state_e              state_q;
  state_e              state_d;
  logic [OPCODE_W-1:0] op_q;
  ctrl_t               ctrl;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the instruction class in DECODE for the later execution states
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q <= OP_RTYPE;
    end else if (state_q == S_DECODE) begin
      op_q <= bus.opcode;
    end
  end

  // Next-state selection; memory states wait on mem_ready
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_RTYPE:       state_d = S_EXEC_R;
          OP_ADDI:        state_d = S_EXEC_I;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_HALT:        state_d = S_HALT;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   state_d = S_ALU_WB;
      S_EXEC_I:   state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  control_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .op_q_i      (op_q),
    .mem_ready_i (bus.mem_ready),
    .reset_i     (reset),
    .ctrl_o      (ctrl)
  );

  assign bus.PCWrite      = ctrl.pc_write;
  assign bus.branchCond   = ctrl.branch_cond;
  assign bus.branchNECond = ctrl.branch_ne_cond;
  assign bus.IRWrite      = ctrl.ir_write;
  assign bus.IorD         = ctrl.i_or_d;
  assign bus.MemRead      = ctrl.mem_read;
  assign bus.MemWrite     = ctrl.mem_write;
  assign bus.RegWrite     = ctrl.reg_write;
  assign bus.MemtoReg     = ctrl.mem_to_reg;
  assign bus.RegDst       = ctrl.reg_dst;
  assign bus.ALUSrcA      = ctrl.alu_src_a;
  assign bus.ALUSrcB      = ctrl.alu_src_b;
  assign bus.ALUOp        = ctrl.alu_op;
  assign bus.PCSource     = ctrl.pc_source;
  assign bus.illegal_op   = ctrl.illegal_op;
  assign bus.halted       = ctrl.halted;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model expands each
// instruction (plus memory wait cycles) into the per-cycle control words it
// must produce; one process drives each cycle and compares the DUT.
module tb_multicycle_control;
  import multicycle_pkg::*;

  typedef struct packed {
    logic pcw, bc, bnc, irw, iord, mrd, mwr, rw, m2r, rdst, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic ill, hlt;
  } cw_t;

  typedef struct {
    logic       rdy;
    logic [3:0] op;
    cw_t        exp;
    string      tag;
  } rec_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  rec_t q[$];
  cw_t  dut_cw;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  assign dut_cw = {bus.PCWrite, bus.branchCond, bus.branchNECond, bus.IRWrite, bus.IorD,
                   bus.MemRead, bus.MemWrite, bus.RegWrite, bus.MemtoReg, bus.RegDst,
                   bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource,
                   bus.illegal_op, bus.halted};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---- model: control word of each kind of cycle ----
  function automatic cw_t w_fetch(input logic r);
    cw_t w = '0;
    w.mrd = 1'b1; w.srcb = 2'b01; w.irw = r; w.pcw = r;
    return w;
  endfunction

  function automatic cw_t w_decode(input logic [3:0] op);
    cw_t w = '0;
    w.srcb = 2'b11;
    w.ill = !(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF});
    return w;
  endfunction

  function automatic cw_t w_alu(input logic srca, input logic [1:0] srcb, input logic [1:0] aluop);
    cw_t w = '0;
    w.srca = srca; w.srcb = srcb; w.aluop = aluop;
    return w;
  endfunction

  function automatic cw_t w_mem(input logic wr);
    cw_t w = '0;
    w.iord = 1'b1; w.mrd = !wr; w.mwr = wr;
    return w;
  endfunction

  function automatic cw_t w_wb(input logic from_mem, input logic rd);
    cw_t w = '0;
    w.rw = 1'b1; w.m2r = from_mem; w.rdst = rd;
    return w;
  endfunction

  function automatic cw_t w_branch(input logic [3:0] op);
    cw_t w = w_alu(1'b1, 2'b00, 2'b01);
    w.pcsrc = 2'b01; w.bc = (op == 4'h4); w.bnc = (op == 4'h5);
    return w;
  endfunction

  function automatic cw_t w_jump();
    cw_t w = '0;
    w.pcw = 1'b1; w.pcsrc = 2'b10;
    return w;
  endfunction

  function automatic cw_t w_halt();
    cw_t w = '0;
    w.hlt = 1'b1;
    return w;
  endfunction

  function automatic void push(input logic r, input logic [3:0] op, input cw_t w, input string tag);
    rec_t rec;
    rec.rdy = r; rec.op = op; rec.exp = w; rec.tag = tag;
    q.push_back(rec);
  endfunction

  // Expand one instruction into its cycles: fw fetch waits, mw memory waits,
  // idle = mem_ready level driven where the memory is not in use.
  function automatic void plan(input logic [3:0] op, input int fw, input int mw, input logic idle);
    for (int i = 0; i < fw; i++) push(1'b0, op, w_fetch(1'b0), "");
    push(1'b1, op, w_fetch(1'b1), "");
    push(idle, op, w_decode(op), w_decode(op).ill ? "ILL" : "");
    case (op)
      4'h0: begin push(idle, op, w_alu(1'b1, 2'b00, 2'b10), ""); push(idle, op, w_wb(1'b0, 1'b1), "R4"); end
      4'h1: begin push(idle, op, w_alu(1'b1, 2'b10, 2'b00), ""); push(idle, op, w_wb(1'b0, 1'b0), ""); end
      4'h2: begin
        push(idle, op, w_alu(1'b1, 2'b10, 2'b00), "");
        for (int i = 0; i < mw; i++) push(1'b0, op, w_mem(1'b0), "");
        push(1'b1, op, w_mem(1'b0), "");
        push(idle, op, w_wb(1'b1, 1'b0), "LW_WB");
      end
      4'h3: begin
        push(idle, op, w_alu(1'b1, 2'b10, 2'b00), "");
        for (int i = 0; i < mw; i++) push(1'b0, op, w_mem(1'b1), "");
        push(1'b1, op, w_mem(1'b1), "");
      end
      4'h4: push(idle, op, w_branch(op), "BEQ3");
      4'h5: push(idle, op, w_branch(op), "BNE3");
      4'h6: push(idle, op, w_jump(), "");
      4'hF: for (int i = 0; i < 20; i++) push(i[0], op, w_halt(), "HALT");
      default: ;
    endcase
  endfunction

  // Drive each planned cycle after the edge, compare at the falling edge
  task automatic run_queue();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      bus.mem_ready = r.rdy;
      bus.opcode    = r.op;
      @(negedge clock);
      check("ctrl_word", 32'(dut_cw), 32'(r.exp));
      if (r.tag == "R4")    check("rtype_wb_lit", {30'd0, dut_cw.rw, dut_cw.rdst}, 32'h3);
      if (r.tag == "LW_WB") check("lw_wb_lit", {30'd0, dut_cw.rw, dut_cw.m2r}, 32'h3);
      if (r.tag == "BEQ3")  check("beq_lit", {27'd0, dut_cw.bc, dut_cw.bnc, dut_cw.pcw, dut_cw.pcsrc}, 32'h11);
      if (r.tag == "BNE3")  check("bne_lit", {27'd0, dut_cw.bc, dut_cw.bnc, dut_cw.pcw, dut_cw.pcsrc}, 32'h09);
      if (r.tag == "ILL")   check("illegal_lit", {29'd0, dut_cw.ill, dut_cw.rw, dut_cw.mwr}, 32'h4);
      if (r.tag == "HALT")  check("halt_lit", {24'd0, dut_cw.hlt, dut_cw.pcw, dut_cw.bc, dut_cw.bnc,
                                               dut_cw.irw, dut_cw.mrd, dut_cw.mwr, dut_cw.rw}, 32'h80);
      @(posedge clock);
      #1;
    end
  endtask

  // Pulse reset asynchronously mid-cycle and confirm FETCH afterwards
  task automatic reset_and_refetch(input string name);
    bus.mem_ready = 1'b0;
    #1 reset = 1'b1;
    #1 check({name, "_zero"}, 32'(dut_cw), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check({name, "_fetch"}, 32'(dut_cw), 32'(w_fetch(1'b0)));
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode = 4'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", 32'(dut_cw), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("first_fetch", 32'(dut_cw), 32'(w_fetch(1'b0)));
    @(posedge clock);
    #1;
    // Reset while FETCH is stalled on memory
    reset_and_refetch("rst_fetch_stall");

    plan(OP_RTYPE, 0, 0, 1'b1);
    plan(OP_ADDI,  1, 0, 1'b0);
    plan(OP_LW,    0, 2, 1'b1);
    plan(OP_SW,    2, 1, 1'b0);
    plan(OP_BEQ,   0, 0, 1'b1);
    plan(OP_BNE,   0, 0, 1'b0);
    plan(OP_J,     0, 0, 1'b1);
    plan(4'h9,     0, 0, 1'b1);
    plan(OP_LW,    0, 0, 1'b0);
    plan(4'hA,     1, 0, 1'b0);
    plan(OP_SW,    0, 0, 1'b1);
    run_queue();

    // LW stalled in its read: reset must drop the request immediately
    push(1'b1, OP_LW, w_fetch(1'b1), "");
    push(1'b1, OP_LW, w_decode(OP_LW), "");
    push(1'b1, OP_LW, w_alu(1'b1, 2'b10, 2'b00), "");
    push(1'b0, OP_LW, w_mem(1'b0), "");
    run_queue();
    #1 check("memrd_still_held", 32'(dut_cw), 32'(w_mem(1'b0)));
    reset_and_refetch("rst_mem_stall");

    plan(OP_HALT, 0, 0, 1'b1);
    run_queue();
    reset_and_refetch("rst_halt");

    plan(OP_RTYPE, 0, 0, 1'b0);
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
